tdm_mux16: RTL and testbench
============================

TDM_MUX16 -- requirements
Module: tdm_mux16

Interface
REQ-001 The block SHALL have one parameter: SLOT_CYCLES, default 4, the clock cycles each enabled channel is held on Q (legal 1..255).
REQ-002 clk  input  1  the single system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 D  input  16  parallel channel inputs; D[i] is channel i.
REQ-005 mask  input  16  channel enable; mask[i]=1 SHALL mean channel i is transmitted.
REQ-006 start  input  1  frame request; sampled only in IDLE.
REQ-007 cont  input  1  continuous mode; sampled at the last cycle of channel 15.
REQ-008 Q  output  1  serial data; the registered, selected channel bit.
REQ-009 A  output  4  registered address of the channel currently on Q; it drives the A3..A0 lines of the far-end 1:16 demultiplexer.
REQ-010 valid  output  1  registered; high while Q carries an enabled channel.
REQ-011 frame_sync  output  1  registered; high only in the first cycle of channel 0.
REQ-012 busy  output  1  registered; high in SCAN.
REQ-013 done  output  1  registered one-cycle end-of-frame pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN and DONE, plus a 4-bit channel counter (ch) and an 8-bit slot counter.
REQ-015 IDLE with start=1 at edge N: D and mask are snapshotted; state=SCAN; ch=0; A=0; frame_sync=1; busy=1; Q=D[0]&mask[0]; valid=mask[0].
REQ-016 In SCAN, Q and valid SHALL come from the snapshot only; changes on D and mask during a frame SHALL NOT affect that frame.
REQ-017 An enabled channel SHALL occupy exactly SLOT_CYCLES cycles with A=ch, Q=snap_D[ch] and valid=1.
REQ-018 A masked channel SHALL occupy exactly 1 cycle with A=ch, Q=0 and valid=0.
REQ-019 At the last cycle of channel ch<15, the next edge SHALL advance ch by 1 and reload the slot counter.
REQ-020 At the last cycle of channel 15 with cont=0, the next state SHALL be DONE, with done=1, busy=0, valid=0, Q=0 and A=0, for one cycle; DONE SHALL then go to IDLE.
REQ-021 At the last cycle of channel 15 with cont=1, the block SHALL re-snapshot D and mask and enter channel 0 on the next edge with no gap cycle; that cycle SHALL carry frame_sync=1 and done=1, and busy SHALL stay 1.
REQ-022 start SHALL be ignored in SCAN and DONE; no queuing.
REQ-023 Frame length in cycles SHALL be SLOT_CYCLES*(number of enabled channels) + (16 - number of enabled channels).
REQ-024 With mask=0 a frame SHALL still run 16 cycles with valid=0 throughout, then pulse done.
REQ-025 Channel order SHALL be 0..15 ascending; A SHALL never skip a value.
REQ-026 The counter SHALL wrap from 15 to 0 only via REQ-020 or REQ-021.
REQ-027 In IDLE: Q=0, valid=0, frame_sync=0, busy=0, done=0 and A holds 0.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for clk, force state=IDLE; Q, A, valid, frame_sync, busy, done and both counters to 0; and snapshots to 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no done pulse.
REQ-030 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-031 SLOT_CYCLES=4, mask=FFFF, D=A5C3, start pulse -> Q per channel 0..15 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 4 cycles; A steps 0..15; done 64 cycles after the start edge; busy high for 64 cycles.
REQ-032 SLOT_CYCLES=4, mask=00FF -> channels 0-7 held 4 cycles with valid=1; channels 8-15 1 cycle each with valid=0 and Q=0; frame length 40.
REQ-033 Toggle D and mask every cycle during the frame of REQ-031 -> Q sequence identical to REQ-031; start pulses during SCAN are ignored (single done).
REQ-034 cont=1, SLOT_CYCLES=1, mask=FFFF -> frame_sync every 16 cycles; done coincides with frame_sync from the second frame onward; busy never drops.
REQ-035 Assert rst_n=0 asynchronously (between clk edges) at channel 7 -> all outputs 0 before the next clk edge; no done; the next start begins a fresh frame at channel 0.

Source files
------------

// File: rtl/tdm_mux16.sv
// Sixteen-channel time-division multiplexer: serialises a snapshot of D onto Q,
// holding each enabled channel SLOT_CYCLES clocks and skipping masked ones in a single clock.
module tdm_mux16 #(
   parameter int unsigned SLOT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] D,
   input  logic [15:0] mask,
   input  logic        start,
   input  logic        cont,
   output logic        Q,
   output logic [3:0]  A,
   output logic        valid,
   output logic        frame_sync,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  ch, ch_nxt;
   logic [7:0]  slot, slot_nxt;
   logic [15:0] snap_d, snap_d_nxt;
   logic [15:0] snap_m, snap_m_nxt;
   logic        last_cycle;
   logic        fs_nxt, done_nxt;
   logic        q_nxt, valid_nxt, busy_nxt;
   logic [3:0]  a_nxt;

   // A masked channel always lasts one cycle, an enabled one SLOT_CYCLES cycles.
   assign last_cycle = !snap_m[ch] || (slot == SLOT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ch         <= '0;
         slot       <= '0;
         snap_d     <= '0;
         snap_m     <= '0;
         Q          <= 1'b0;
         A          <= '0;
         valid      <= 1'b0;
         frame_sync <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         ch         <= ch_nxt;
         slot       <= slot_nxt;
         snap_d     <= snap_d_nxt;
         snap_m     <= snap_m_nxt;
         Q          <= q_nxt;
         A          <= a_nxt;
         valid      <= valid_nxt;
         frame_sync <= fs_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ch_nxt     = ch;
      slot_nxt   = slot;
      snap_d_nxt = snap_d;
      snap_m_nxt = snap_m;
      fs_nxt     = 1'b0;
      done_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = SCAN;
               ch_nxt     = '0;
               slot_nxt   = '0;
               snap_d_nxt = D;
               snap_m_nxt = mask;
               fs_nxt     = 1'b1;
            end
         end
         SCAN: begin
            if (!last_cycle) begin
               slot_nxt = slot + 8'd1;
            end else if (ch != 4'd15) begin
               ch_nxt   = ch + 4'd1;
               slot_nxt = '0;
            end else if (cont) begin
               // Back-to-back frame: fresh snapshot, no gap cycle.
               ch_nxt     = '0;
               slot_nxt   = '0;
               snap_d_nxt = D;
               snap_m_nxt = mask;
               fs_nxt     = 1'b1;
               done_nxt   = 1'b1;
            end else begin
               state_nxt = DONE;
               ch_nxt    = '0;
               slot_nxt  = '0;
               done_nxt  = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are registered from the upcoming state so they line up with it.
   always_comb begin
      busy_nxt  = (state_nxt == SCAN);
      a_nxt     = busy_nxt ? ch_nxt : 4'd0;
      valid_nxt = busy_nxt & snap_m_nxt[ch_nxt];
      q_nxt     = busy_nxt & snap_m_nxt[ch_nxt] & snap_d_nxt[ch_nxt];
   end

endmodule

// File: tb/tb_tdm_mux16.sv
// Randomised bench for tdm_mux16: two instances (SLOT_CYCLES 4 and 1) share stimulus
// and are compared every cycle against a frame-list reference model.
module tb_tdm_mux16;

   typedef struct packed {
      logic       q;
      logic [3:0] a;
      logic       valid;
      logic       fs;
      logic       busy;
      logic       done;
      logic       last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] D, mask;
   logic        start, cont;

   logic        q4, v4, fs4, b4, d4;
   logic [3:0]  a4;
   logic        q1, v1, fs1, b1, d1;
   logic [3:0]  a1;
   logic [8:0]  obs [2];

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q [2][$];
   exp_t cur   [2];

   int   busy_cnt4, done_cnt4, fs_cnt1, busy_low1;

   always #5 clk = ~clk;

   tdm_mux16 #(.SLOT_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .D(D), .mask(mask), .start(start), .cont(cont),
      .Q(q4), .A(a4), .valid(v4), .frame_sync(fs4), .busy(b4), .done(d4)
   );

   tdm_mux16 #(.SLOT_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .D(D), .mask(mask), .start(start), .cont(cont),
      .Q(q1), .A(a1), .valid(v1), .frame_sync(fs1), .busy(b1), .done(d1)
   );

   assign obs[0] = {q4, a4, v4, fs4, b4, d4};
   assign obs[1] = {q1, a1, v1, fs1, b1, d1};

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [15:0] m,
                                input logic s, input logic c);
      D     = d;
      mask  = m;
      start = s;
      cont  = c;
   endtask

   function automatic int slot_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   // Expand one frame into the list of per-cycle output tuples it must produce.
   task automatic build_frame(input int i, input logic [15:0] d, input logic [15:0] m,
                              input logic chained);
      exp_t e;
      int   n;
      for (int c = 0; c < 16; c++) begin
         n = m[c] ? slot_of(i) : 1;
         for (int k = 0; k < n; k++) begin
            e       = '0;
            e.q     = m[c] & d[c];
            e.a     = 4'(c);
            e.valid = m[c];
            e.fs    = (c == 0 && k == 0);
            e.busy  = 1'b1;
            e.done  = chained && c == 0 && k == 0;
            e.last  = (c == 15 && k == n - 1);
            exp_q[i].push_back(e);
         end
      end
   endtask

   task automatic model_reset;
      for (int i = 0; i < 2; i++) begin
         exp_q[i].delete();
         cur[i] = '0;
      end
   endtask

   task automatic model_edge;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            exp_q[i].delete();
            cur[i] = '0;
         end else begin
            if (cur[i].last) begin
               if (cont) begin
                  build_frame(i, D, mask, 1'b1);
               end else begin
                  e      = '0;
                  e.done = 1'b1;
                  exp_q[i].push_back(e);
               end
            end else if (exp_q[i].size() == 0 && !cur[i].busy && !cur[i].done && start) begin
               build_frame(i, D, mask, 1'b0);
            end
            cur[i] = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : '0;
         end
      end
   endtask

   task automatic step_cycle;
      @(posedge clk);
      model_edge();
      #1;
      checkOutput("slot4_out", 32'(obs[0]),
                  32'({cur[0].q, cur[0].a, cur[0].valid, cur[0].fs, cur[0].busy, cur[0].done}));
      checkOutput("slot1_out", 32'(obs[1]),
                  32'({cur[1].q, cur[1].a, cur[1].valid, cur[1].fs, cur[1].busy, cur[1].done}));
      busy_cnt4 += int'(b4);
      done_cnt4 += int'(d4);
      fs_cnt1   += int'(fs1);
      busy_low1 += int'(!b1);
   endtask

   task automatic clear_counts;
      busy_cnt4 = 0;
      done_cnt4 = 0;
      fs_cnt1   = 0;
      busy_low1 = 0;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) step_cycle();
   endtask

   initial begin
      logic [15:0] pattern;
      int          n_en;
      pattern = 16'hA5C3;
      model_reset();
      rst_n = 1'b0;
      applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
      run_cycles(2);
      #2 rst_n = 1'b1;
      run_cycles(3);

      // Reference frame with D and mask scrambled every cycle and stray start pulses.
      clear_counts();
      applyStimulus(pattern, 16'hFFFF, 1'b1, 1'b0);
      step_cycle();
      checkOutput("q_ch", 32'(q4), 32'(pattern[0]));
      for (int j = 1; j <= 70; j++) begin
         applyStimulus(16'($urandom), 16'($urandom), (j < 55) && ($urandom_range(0, 3) == 0), 1'b0);
         step_cycle();
         if (j < 64 && j % 4 == 0) checkOutput("q_ch", 32'(q4), 32'(pattern[j / 4]));
         if (j == 60) checkOutput("addr_ch15", 32'(a4), 32'd15);
      end
      checkOutput("busy_len_full", busy_cnt4, 4 * 16);
      checkOutput("done_single", done_cnt4, 1);

      // Half-masked and fully-masked frames: length = SLOT*n + (16-n).
      for (int t = 0; t < 2; t++) begin
         clear_counts();
         mask = (t == 0) ? 16'h00FF : 16'h0000;
         n_en = $countones(mask);
         applyStimulus(16'($urandom), mask, 1'b1, 1'b0);
         step_cycle();
         applyStimulus(D, mask, 1'b0, 1'b0);
         run_cycles(50);
         checkOutput("busy_len_mask", busy_cnt4, 4 * n_en + (16 - n_en));
         checkOutput("done_mask", done_cnt4, 1);
      end

      // Continuous mode: no gap between frames.
      clear_counts();
      applyStimulus(16'($urandom), 16'hFFFF, 1'b1, 1'b1);
      step_cycle();
      for (int j = 1; j < 70; j++) begin
         applyStimulus(16'($urandom), 16'hFFFF, 1'b0, 1'b1);
         step_cycle();
      end
      checkOutput("cont_fs_count", fs_cnt1, 5);
      checkOutput("cont_busy_low", busy_low1, 0);
      checkOutput("cont_no_done4", done_cnt4, 1);
      applyStimulus(D, mask, 1'b0, 1'b0);
      run_cycles(80);
      checkOutput("cont_end_idle", 32'({b4, b1}), 32'd0);

      // Asynchronous reset in the middle of channel 7.
      clear_counts();
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      step_cycle();
      applyStimulus(D, mask, 1'b0, 1'b0);
      run_cycles(28);
      checkOutput("ch7_before_rst", 32'(a4), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_slot4", 32'(obs[0]), 32'd0);
      checkOutput("async_rst_slot1", 32'(obs[1]), 32'd0);
      model_reset();
      run_cycles(2);
      #2 rst_n = 1'b1;
      run_cycles(3);
      checkOutput("rst_no_done", done_cnt4, 0);
      clear_counts();
      applyStimulus(16'($urandom), 16'hFFFF, 1'b1, 1'b0);
      step_cycle();
      checkOutput("fresh_ch0", 32'({a4, fs4}), 32'h1);
      applyStimulus(D, mask, 1'b0, 1'b0);
      run_cycles(70);
      checkOutput("fresh_len", busy_cnt4, 64);
      checkOutput("fresh_done", done_cnt4, 1);

      // Free-running random traffic, then drain.
      for (int j = 0; j < 400; j++) begin
         applyStimulus(16'($urandom), ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFF,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
         step_cycle();
      end
      applyStimulus(D, mask, 1'b0, 1'b0);
      run_cycles(150);
      checkOutput("drain_idle", 32'({b4, b1}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
